// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types and default limits for the data memory arbiter.
// Used by the arbiter, its FSM and its bus interface.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    CPU_OWN,
    DRAIN,
    HOST_ACC,
    HOST_RD
  } arb_state_t;

  localparam int ADDR_W_DEF    = 4;
  localparam int DATA_W_DEF    = 4;
  localparam int MAX_WAIT_DEF  = 8;
  localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: CPU, host and memory side signals of the data memory arbiter.
// slave = arbiter view, master = surrounding system view.
interface dm_arbiter_if
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_wren;
  logic              cpu_hold;
  logic              cpu_err;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wren,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_q,
    output cpu_hold, cpu_err,
    output host_gnt, host_rdata, host_valid,
    output mem_addr, mem_data, mem_wren
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_wren,
    output host_req, host_we, host_addr, host_wdata,
    output mem_q,
    input  cpu_hold, cpu_err,
    input  host_gnt, host_rdata, host_valid,
    input  mem_addr, mem_data, mem_wren
  );

endinterface

// File: rtl/dm_arb_fsm.sv
// dm_arb_fsm: ownership state, host wait / burst counters, sticky CPU error.
// With DM_ARB_STATS_EN it also flags each entry into HOST_ACC.
module dm_arb_fsm
  import dm_arb_pkg::*;
#(
  parameter int MAX_WAIT  = MAX_WAIT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_req,
  input  logic       host_we,
  input  logic       cpu_wren,
  output arb_state_t state,
`ifdef DM_ARB_STATS_EN
  output logic       acc_entry,
`endif
  output logic       cpu_hold,
  output logic       host_gnt,
  output logic       cpu_err
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_TOP  = WW'(MAX_WAIT - 1);
  localparam logic [BW-1:0] BURST_TOP = BW'(MAX_BURST - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  arb_state_t    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          err_q, err_d;
  logic          held;

  assign state = state_q;
  assign held  = (state_q == HOST_ACC) || (state_q == HOST_RD);

  // state and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CPU_OWN;
      wait_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

  // next-state, counter and sticky error logic
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    err_d   = err_q | (cpu_wren & held);
    unique case (state_q)
      CPU_OWN: begin
        if (!host_req) begin
          wait_d = '0;
        end else if (!cpu_wren) begin
          state_d = HOST_ACC;
          wait_d  = '0;
        end else if (wait_q == WAIT_TOP) begin
          state_d = DRAIN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DRAIN: state_d = HOST_ACC;
      HOST_ACC: begin
        if (!host_req) begin
          state_d = CPU_OWN;
        end else begin
          burst_d = burst_q + 1'b1;
          if (!host_we) begin
            state_d = HOST_RD;
          end else if (burst_q == BURST_TOP) begin
            state_d = CPU_OWN;
          end
        end
      end
      HOST_RD: begin
        if (host_req && (burst_q < BURST_MAX)) begin
          state_d = HOST_ACC;
        end else begin
          state_d = CPU_OWN;
        end
      end
      default: state_d = CPU_OWN;
    endcase
    if (state_d == CPU_OWN) begin
      burst_d = '0;
    end
  end

  // outputs decoded from the state register
  always_comb begin
    cpu_hold = (state_q != CPU_OWN);
    host_gnt = (state_q == HOST_ACC);
    cpu_err  = err_q;
`ifdef DM_ARB_STATS_EN
    acc_entry = (state_d == HOST_ACC) && (state_q != HOST_ACC);
`endif
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the data memory between CPU and host/debug port.
// DM_ARB_STATS_EN adds saturating grant and stall counters.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic        clk,
  input  logic        reset,
`ifdef DM_ARB_STATS_EN
  output logic [15:0] stat_grants,
  output logic [15:0] stat_stall,
`endif
  dm_arbiter_if.slave bus
);

  arb_state_t        state;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;
`ifdef DM_ARB_STATS_EN
  logic              acc_entry;
  logic [15:0]       grants_q, grants_d;
  logic [15:0]       stall_q, stall_d;
`endif

  dm_arb_fsm #(
    .MAX_WAIT  (MAX_WAIT),
    .MAX_BURST (MAX_BURST)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .host_req  (bus.host_req),
    .host_we   (bus.host_we),
    .cpu_wren  (bus.cpu_wren),
    .state     (state),
`ifdef DM_ARB_STATS_EN
    .acc_entry (acc_entry),
`endif
    .cpu_hold  (bus.cpu_hold),
    .host_gnt  (bus.host_gnt),
    .cpu_err   (bus.cpu_err)
  );

  // memory mux: CPU by default, host while granted, latched addr on read
  always_comb begin
    bus.mem_addr = bus.cpu_addr;
    bus.mem_data = bus.cpu_wdata;
    bus.mem_wren = bus.cpu_wren;
    unique case (state)
      HOST_ACC: begin
        bus.mem_addr = bus.host_addr;
        bus.mem_data = bus.host_wdata;
        bus.mem_wren = bus.host_req & bus.host_we;
      end
      HOST_RD: begin
        bus.mem_addr = haddr_q;
        bus.mem_data = bus.host_wdata;
        bus.mem_wren = 1'b0;
      end
      default: ;
    endcase
  end

  // host address latch and read data capture
  always_comb begin
    haddr_d = haddr_q;
    if ((state == HOST_ACC) && bus.host_req) begin
      haddr_d = bus.host_addr;
    end
    rdata_d = rdata_q;
    valid_d = (state == HOST_RD);
    if (state == HOST_RD) begin
      rdata_d = bus.mem_q;
    end
  end

  // host-side registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      haddr_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      haddr_q <= haddr_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign bus.host_rdata = rdata_q;
  assign bus.host_valid = valid_q;

`ifdef DM_ARB_STATS_EN
  // saturating grant-entry and stall-cycle counters
  always_comb begin
    grants_d = grants_q;
    stall_d  = stall_q;
    if (acc_entry && (grants_q != 16'hFFFF)) begin
      grants_d = grants_q + 16'd1;
    end
    if (bus.cpu_hold && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // statistics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants_q <= '0;
      stall_q  <= '0;
    end else begin
      grants_q <= grants_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_grants = grants_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed stimulus with a write/read scoreboard.
// Models the 16x4 data memory clocked on the falling edge.
module tb_dm_arbiter;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  wr_t  wq[$];
  logic [3:0] rq[$];
  logic [3:0] mem [16];
  wr_t  w;
  logic [3:0] r;

`ifdef DM_ARB_STATS_EN
  logic [15:0] stat_grants;
  logic [15:0] stat_stall;
`endif

  dm_arbiter_if bus ();

  dm_arbiter dut (
    .clk         (clk),
    .reset       (reset),
`ifdef DM_ARB_STATS_EN
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // external data memory, clocked on the falling edge
  always @(negedge clk) begin
    if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_data;
    bus.mem_q <= mem[bus.mem_addr];
  end

  // monitor: pop and compare on every memory write and read strobe
  always @(negedge clk) begin
    #2;
    if (bus.mem_wren) begin
      n_vec++;
      if (wq.size() == 0) begin
        n_err++;
        $display("FAIL mem_write: got addr %0h data %0h, required no write",
                 bus.mem_addr, bus.mem_data);
      end else begin
        w = wq.pop_front();
        if (bus.mem_addr !== w.a || bus.mem_data !== w.d) begin
          n_err++;
          $display("FAIL mem_write: got addr %0h data %0h, required addr %0h data %0h",
                   bus.mem_addr, bus.mem_data, w.a, w.d);
        end
      end
    end
    if (bus.host_valid) begin
      n_vec++;
      if (rq.size() == 0) begin
        n_err++;
        $display("FAIL host_read: got valid data %0h, required no strobe",
                 bus.host_rdata);
      end else begin
        r = rq.pop_front();
        if (bus.host_rdata !== r) begin
          n_err++;
          $display("FAIL host_read: got %0h, required %0h", bus.host_rdata, r);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic we, input logic [3:0] a,
                         input logic [3:0] d);
    bus.cpu_wren  = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic set_host(input logic req, input logic we,
                          input logic [3:0] a, input logic [3:0] d);
    bus.host_req   = req;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = d;
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [3:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wq.push_back(e);
  endtask

  logic       bgnt [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
  logic       breq [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  logic       bpush[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  logic [3:0] bword[10] = '{0, 0, 1, 2, 3, 4, 4, 5, 0, 0};

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    bus.mem_q = 4'h0;
    reset = 1'b1;
    set_cpu(0, 0, 0);
    set_host(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    chk("rst_hold", bus.cpu_hold, 0);
    chk("rst_gnt", bus.host_gnt, 0);
    chk("rst_valid", bus.host_valid, 0);
    chk("rst_rdata", bus.host_rdata, 0);
    chk("rst_err", bus.cpu_err, 0);
    reset = 1'b0;

    // CPU write with idle host
    tick(); set_cpu(1, 4'h3, 4'hA); push_wr(4'h3, 4'hA);
    #2;
    chk("cpu_wr_wren", bus.mem_wren, 1);
    chk("cpu_wr_addr", bus.mem_addr, 4'h3);
    chk("cpu_wr_data", bus.mem_data, 4'hA);
    chk("cpu_wr_hold", bus.cpu_hold, 0);
    tick(); set_cpu(0, 0, 0);

    // host write addr 5 = 7
    tick(); set_host(1, 1, 4'h5, 4'h7);
    #2 chk("hw_req_gnt", bus.host_gnt, 0);
    tick(); push_wr(4'h5, 4'h7);
    #2;
    chk("hw_gnt", bus.host_gnt, 1);
    chk("hw_addr", bus.mem_addr, 4'h5);
    tick(); set_host(0, 0, 0, 0);
    #2;
    chk("hw_drop_gnt", bus.host_gnt, 1);
    chk("hw_drop_wren", bus.mem_wren, 0);
    tick();
    #2 chk("hw_back_hold", bus.cpu_hold, 0);

    // host read addr 5
    tick(); set_host(1, 0, 4'h5, 4'h0);
    tick(); rq.push_back(4'h7);
    #2 chk("hr_gnt", bus.host_gnt, 1);
    tick(); set_host(0, 0, 0, 0);
    #2;
    chk("hr_rd_hold", bus.cpu_hold, 1);
    chk("hr_rd_valid", bus.host_valid, 0);
    tick();
    #2;
    chk("hr_valid", bus.host_valid, 1);
    chk("hr_rdata", bus.host_rdata, 4'h7);
    tick();
    #2 chk("hr_valid_end", bus.host_valid, 0);

    // CPU writes every cycle while host waits -> drain then grant
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k <= 9) begin
        set_cpu(1, 4'(k + 5), 4'(k));
        push_wr(4'(k + 5), 4'(k));
      end else begin
        set_cpu(0, 0, 0);
        push_wr(4'hF, 4'h3);
      end
      set_host(1, 1, 4'hF, 4'h3);
      #2;
      chk($sformatf("dr_hold_%0d", k), bus.cpu_hold, (k >= 9) ? 1 : 0);
      chk($sformatf("dr_gnt_%0d", k), bus.host_gnt, (k == 10) ? 1 : 0);
    end
    tick(); set_host(0, 0, 0, 0);
    #2 chk("dr_tail_gnt", bus.host_gnt, 1);
    tick();
    #2;
    chk("dr_back_hold", bus.cpu_hold, 0);
    chk("dr_last_cpu_wr", mem[14], 4'h9);
    chk("dr_host_wr", mem[15], 4'h3);
    chk("dr_err", bus.cpu_err, 0);

    // host requests 6 writes: burst of 4, one CPU cycle, then 2
    for (int b = 0; b < 10; b++) begin
      tick();
      set_host(breq[b], 1, bword[b], bword[b] + 4'h8);
      if (bpush[b]) push_wr(bword[b], bword[b] + 4'h8);
      #2;
      chk($sformatf("bu_gnt_%0d", b), bus.host_gnt, bgnt[b]);
      chk($sformatf("bu_hold_%0d", b), bus.cpu_hold, bgnt[b]);
    end

    // CPU write during host access is discarded and flagged
    tick(); set_host(1, 1, 4'h7, 4'h2);
    tick(); push_wr(4'h7, 4'h2); set_cpu(1, 4'h2, 4'hF);
    #2;
    chk("ce_gnt", bus.host_gnt, 1);
    chk("ce_addr", bus.mem_addr, 4'h7);
    tick(); set_host(0, 0, 0, 0); set_cpu(0, 0, 0);
    #2 chk("ce_err_set", bus.cpu_err, 1);
    tick();
    #2;
    chk("ce_hold", bus.cpu_hold, 0);
    chk("ce_mem2", mem[2], 4'hA);
    repeat (3) tick();
    #2 chk("ce_err_sticky", bus.cpu_err, 1);

    // reset during HOST_RD acts without a clock edge
    tick(); set_host(1, 0, 4'h4, 4'h0);
    tick();
    #2 chk("rr_gnt", bus.host_gnt, 1);
    tick(); set_host(0, 0, 0, 0);
    #1 chk("rr_rd_hold", bus.cpu_hold, 1);
    #1 reset = 1'b1;
    #1;
    chk("rr_hold", bus.cpu_hold, 0);
    chk("rr_gnt0", bus.host_gnt, 0);
    chk("rr_valid", bus.host_valid, 0);
    chk("rr_rdata", bus.host_rdata, 0);
    chk("rr_err", bus.cpu_err, 0);
    tick(); reset = 1'b0;
    tick(); set_cpu(1, 4'h1, 4'h6); push_wr(4'h1, 4'h6);
    #2;
    chk("rr_cpu_hold", bus.cpu_hold, 0);
    chk("rr_cpu_wren", bus.mem_wren, 1);
    tick(); set_cpu(0, 0, 0);

    repeat (3) tick();
    chk("sb_wr_left", 16'(wq.size()), 0);
    chk("sb_rd_left", 16'(rq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
